// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Package     : seven_seg_pkg
// Description : Shared widths, scanner states and anode decode for the
//               seven-segment register file and its display scanner.
// Revision    : 1.0
// ============================================================================
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = $clog2(NUM_DIGITS);
    localparam int ADDR_W     = 4;
    localparam int SEG_W      = 7;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        LOAD  = 2'd2,
        SHOW  = 2'd3
    } state_t;

    // Digit 0 is the leftmost position, which is driven by AN[NUM_DIGITS-1].
    function automatic logic [NUM_DIGITS-1:0] an_select(input logic [DIGIT_W-1:0] digit);
        logic [NUM_DIGITS-1:0] w_msb;
        w_msb = {1'b1, {(NUM_DIGITS-1){1'b0}}};
        return ~(w_msb >> digit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_scanner_if.sv
`default_nettype none
// ============================================================================
// Interface   : seven_seg_scanner_if
// Description : Read port of the segment register file: address bits out,
//               combinational segment code back.
// Revision    : 1.0
// ============================================================================
interface seven_seg_scanner_if;
    import seven_seg_pkg::*;

    logic             RA3;
    logic             RA2;
    logic             RA1;
    logic             RA0;
    logic [SEG_W-1:0] DATA;

    modport master (
        output RA3, RA2, RA1, RA0,
        input  DATA
    );

    modport slave (
        input  RA3, RA2, RA1, RA0,
        output DATA
    );

endinterface
`default_nettype wire

// File: rtl/tick_div.sv
`default_nettype none
// ============================================================================
// Module      : tick_div
// Description : Modulo-N counter with synchronous active-low clear and a
//               terminal-count pulse; optionally holds at N-1.
// Revision    : 1.0
// ============================================================================
module tick_div #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  wire logic clk,
    input  wire logic i_clr_n,
    input  wire logic i_en,
    input  wire logic i_wrap_ok,
    output logic      o_tc
);

    localparam logic [W-1:0] c_LAST = W'(N - 1);

    logic [W-1:0] r_count;
    logic         w_at_last;

    assign w_at_last = (r_count == c_LAST);

    // With i_wrap_ok low the count parks at N-1 instead of wrapping.
    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_count <= '0;
        end else if (i_en && !w_at_last) begin
            r_count <= r_count + W'(1);
        end else if (i_en && i_wrap_ok) begin
            r_count <= '0;
        end
    end

    assign o_tc = i_clr_n & i_en & i_wrap_ok & w_at_last;

endmodule
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scanner
// Description : Time-multiplexed four-digit common-anode driver that scrolls
//               a window across the 16-entry segment register file.
// Revision    : 1.0
// ============================================================================
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 1000,
    parameter int SCROLL_DIV  = 250
) (
    input  wire logic                  CLK,
    input  wire logic                  CLRN,
    input  wire logic                  EN,
    input  wire logic                  SCROLL_EN,
    seven_seg_scanner_if.master        rf,
    output logic [SEG_W-1:0]           SEG,
    output logic [NUM_DIGITS-1:0]      AN,
    output logic                       WRAP
);

    localparam int                 c_PCNT_W     = $clog2(REFRESH_DIV);
    localparam int                 c_FCNT_W     = $clog2(SCROLL_DIV + 1);
    localparam logic [DIGIT_W-1:0] c_LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);
    localparam logic [ADDR_W-1:0]  c_LAST_BASE  = '1;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DIGIT_W-1:0]      r_digit;
    logic [DIGIT_W-1:0]      w_digit_nxt;
    logic [ADDR_W-1:0]       r_base;
    logic [ADDR_W-1:0]       w_base_nxt;
    logic [ADDR_W-1:0]       r_ra;
    logic [ADDR_W-1:0]       w_ra_nxt;
    logic [SEG_W-1:0]        r_seg;
    logic [SEG_W-1:0]        w_seg_nxt;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [NUM_DIGITS-1:0]   w_an_nxt;
    logic                    r_wrap;

    logic                    w_pcnt_clr_n;
    logic                    w_slot_tc;
    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_step;

    // Slot counter runs from the BLANK cycle; it is held clear while idle so
    // every slot, including the first after enable, is exactly REFRESH_DIV.
    assign w_pcnt_clr_n = CLRN & EN & (r_state != IDLE);

    tick_div #(
        .N (REFRESH_DIV),
        .W (c_PCNT_W)
    ) u_pcnt (
        .clk       (CLK),
        .i_clr_n   (w_pcnt_clr_n),
        .i_en      (1'b1),
        .i_wrap_ok (1'b1),
        .o_tc      (w_slot_tc)
    );

    assign w_slot_end  = w_slot_tc & (r_state == SHOW);
    assign w_frame_end = w_slot_end & (r_digit == c_LAST_DIGIT);

    // Frame counter parks at SCROLL_DIV-1 while scrolling is frozen, so the
    // step is taken at the first frame end after SCROLL_EN returns.
    tick_div #(
        .N (SCROLL_DIV),
        .W (c_FCNT_W)
    ) u_fcnt (
        .clk       (CLK),
        .i_clr_n   (CLRN),
        .i_en      (w_frame_end),
        .i_wrap_ok (SCROLL_EN),
        .o_tc      (w_step)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_digit_nxt = r_digit;
        w_base_nxt  = r_base;
        w_ra_nxt    = r_ra;
        w_seg_nxt   = r_seg;
        w_an_nxt    = r_an;

        if (!EN) begin
            w_state_nxt = IDLE;
            w_digit_nxt = '0;
            w_an_nxt    = AN_OFF;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = BLANK;
                    w_digit_nxt = '0;
                    w_an_nxt    = AN_OFF;
                    w_ra_nxt    = r_base;
                end
                BLANK: begin
                    w_state_nxt = LOAD;
                    w_seg_nxt   = rf.DATA;
                end
                LOAD: begin
                    w_state_nxt = SHOW;
                    w_an_nxt    = an_select(r_digit);
                end
                SHOW: begin
                    if (w_slot_end) begin
                        w_state_nxt = BLANK;
                        w_digit_nxt = r_digit + DIGIT_W'(1);
                        w_an_nxt    = AN_OFF;
                        if (w_step) begin
                            w_base_nxt = r_base + ADDR_W'(1);
                        end
                        // Address follows the updated base/digit so RA is
                        // valid for the whole BLANK cycle.
                        w_ra_nxt = w_base_nxt + ADDR_W'(w_digit_nxt);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_an_nxt    = AN_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLRN) begin
            r_state <= IDLE;
            r_digit <= '0;
            r_base  <= '0;
            r_ra    <= '0;
            r_seg   <= '0;
            r_an    <= AN_OFF;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_digit <= w_digit_nxt;
            r_base  <= w_base_nxt;
            r_ra    <= w_ra_nxt;
            r_seg   <= w_seg_nxt;
            r_an    <= w_an_nxt;
            r_wrap  <= w_step & (r_base == c_LAST_BASE);
        end
    end

    assign {rf.RA3, rf.RA2, rf.RA1, rf.RA0} = r_ra;
    assign SEG  = r_seg;
    assign AN   = r_an;
    assign WRAP = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scanner
// Description : Directed bench for seven_seg_scanner; two instances with
//               REFRESH_DIV=4 and SCROLL_DIV of 1 (a) and 2 (b).
// Revision    : 1.0
// ============================================================================
module tb_seven_seg_scanner;

    logic       clk = 1'b0;
    logic       clrn;
    logic       en;
    logic       scroll_en;
    logic [6:0] seg_a;
    logic [6:0] seg_b;
    logic [3:0] an_a;
    logic [3:0] an_b;
    logic       wrap_a;
    logic       wrap_b;
    logic [3:0] ra_a;
    logic [3:0] ra_b;
    logic [6:0] mem [16];

    int n_checks = 0;
    int n_pass   = 0;

    seven_seg_scanner_if if_a ();
    seven_seg_scanner_if if_b ();

    assign ra_a = {if_a.RA3, if_a.RA2, if_a.RA1, if_a.RA0};
    assign ra_b = {if_b.RA3, if_b.RA2, if_b.RA1, if_b.RA0};
    assign if_a.DATA = mem[ra_a];
    assign if_b.DATA = mem[ra_b];

    seven_seg_scanner #(.REFRESH_DIV(4), .SCROLL_DIV(1)) dut_a (
        .CLK       (clk),
        .CLRN      (clrn),
        .EN        (en),
        .SCROLL_EN (scroll_en),
        .rf        (if_a),
        .SEG       (seg_a),
        .AN        (an_a),
        .WRAP      (wrap_a)
    );

    seven_seg_scanner #(.REFRESH_DIV(4), .SCROLL_DIV(2)) dut_b (
        .CLK       (clk),
        .CLRN      (clrn),
        .EN        (en),
        .SCROLL_EN (scroll_en),
        .rf        (if_b),
        .SEG       (seg_b),
        .AN        (an_b),
        .WRAP      (wrap_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 16-cycle frame starting with the edge that enters BLANK of digit 0.
    task automatic run_frame(input int fr, input logic [3:0] ba, input logic [3:0] bb,
                             input logic wa);
        logic [3:0] exp_an;
        logic [3:0] adr_a;
        logic [3:0] adr_b;
        for (int d = 0; d < 4; d++) begin
            adr_a = ba + 4'(d);
            adr_b = bb + 4'(d);
            for (int s = 0; s < 4; s++) begin
                step();
                exp_an = (s < 2) ? 4'b1111 : (4'b1111 ^ (4'b1000 >> d));
                check($sformatf("f%0d d%0d s%0d AN_a", fr, d, s), 32'(an_a), 32'(exp_an));
                check($sformatf("f%0d d%0d s%0d AN_b", fr, d, s), 32'(an_b), 32'(exp_an));
                check($sformatf("f%0d d%0d s%0d WRAP_a", fr, d, s), 32'(wrap_a),
                      32'((d == 0 && s == 0) ? wa : 1'b0));
                check($sformatf("f%0d d%0d s%0d WRAP_b", fr, d, s), 32'(wrap_b), 32'(0));
                if (s == 0) begin
                    check($sformatf("f%0d d%0d RA_a", fr, d), 32'(ra_a), 32'(adr_a));
                    check($sformatf("f%0d d%0d RA_b", fr, d), 32'(ra_b), 32'(adr_b));
                end
                if (s == 1) begin
                    check($sformatf("f%0d d%0d SEG_a", fr, d), 32'(seg_a), 32'(mem[adr_a]));
                    check($sformatf("f%0d d%0d SEG_b", fr, d), 32'(seg_b), 32'(mem[adr_b]));
                end
            end
        end
    endtask

    initial begin
        int bad;
        int low_a;

        mem[0] = 7'h01;
        mem[1] = 7'h02;
        mem[2] = 7'h04;
        mem[3] = 7'h08;
        for (int i = 4; i < 16; i++) mem[i] = 7'(8'h10 + i);

        // Reset held with EN=1: reset must win.
        clrn      = 1'b0;
        en        = 1'b1;
        scroll_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst%0d AN_a", i), 32'(an_a), 32'hF);
            check($sformatf("rst%0d SEG_a", i), 32'(seg_a), 32'h0);
            check($sformatf("rst%0d RA_a", i), 32'(ra_a), 32'h0);
            check($sformatf("rst%0d WRAP_a", i), 32'(wrap_a), 32'h0);
            check($sformatf("rst%0d AN_b", i), 32'(an_b), 32'hF);
        end
        clrn = 1'b1;

        // Scan order plus scroll hold: five frames with SCROLL_EN=0.
        for (int k = 1; k <= 5; k++) run_frame(k, 4'd0, 4'd0, 1'b0);

        // Scroll: a steps every frame, b every second frame; a wraps at frame 21.
        scroll_en = 1'b1;
        for (int k = 6; k <= 22; k++)
            run_frame(k, 4'(k - 5), 4'(1 + (k - 6) / 2), k == 21);

        // Mid-slot disable during SHOW of digit 2 (a base 2, b base 9).
        for (int i = 0; i < 11; i++) step();
        check("mid AN_a show d2", 32'(an_a), 32'b1101);
        check("mid AN_b show d2", 32'(an_b), 32'b1101);
        en = 1'b0;
        step();
        check("dis AN_a", 32'(an_a), 32'hF);
        check("dis AN_b", 32'(an_b), 32'hF);
        step();
        step();
        check("dis AN_a hold", 32'(an_a), 32'hF);
        check("dis SEG_a hold", 32'(seg_a), 32'(mem[4]));
        en = 1'b1;
        run_frame(23, 4'd2, 4'd9, 1'b0);

        // 1000 slots: never two anodes low, exactly 2 lit cycles per slot.
        bad   = 0;
        low_a = 0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if ($countones(~an_a) > 1) bad++;
            if ($countones(~an_b) > 1) bad++;
            if (an_a != 4'hF) low_a++;
        end
        check("multi-anode cycles", 32'(bad), 32'd0);
        check("lit cycles a", 32'(low_a), 32'd2000);

        // Frame end with scroll pending but EN dropped: base must not move.
        en = 1'b0;
        step();
        check("endis AN_a", 32'(an_a), 32'hF);
        en = 1'b1;
        step();
        check("endis RA_a base", 32'(ra_a), 32'd12);
        check("endis RA_b base", 32'(ra_b), 32'd6);
        check("endis WRAP_a", 32'(wrap_a), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
